heating_sched: RTL and testbench

Thermostat scheduler that sequences the heating/cooling unit. It compares sampled temperature readings against a setpoint with hysteresis and drives the unit's heat request (A) and cool request (B). It enforces minimum run time, a dead-time lockout between runs, and a maximum-run fault. It sits between the temperature sensor interface and the heating unit's A/B inputs.

---
 rtl/heating_sched.sv | 132 +++++++++++++
 tb/tb_heating_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/heating_sched.sv
// Thermostat scheduler: hysteresis compare against a setpoint, heat/cool run sequencing with
// minimum run time, dead-time lockout between runs and a maximum-run fault.
module heating_sched #(
    parameter int unsigned TEMP_W   = 8,
    parameter int unsigned HYST     = 2,
    parameter int unsigned MIN_ON   = 16,
    parameter int unsigned DEAD_CYC = 8,
    parameter int unsigned MAX_RUN  = 1024,
    parameter int unsigned CNT_W    = 12
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              enable,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temp,
    input  logic [TEMP_W-1:0] setpoint,
    input  logic              clear_fault,
    output logic              heat_req,
    output logic              cool_req,
    output logic              fault,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StHeat  = 3'd1,
        StCool  = 3'd2,
        StDead  = 3'd3,
        StFault = 3'd4
    } state_e;

    localparam int unsigned CW = TEMP_W + 1;
    localparam logic [CNT_W-1:0] DeadLast = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] RunLast  = CNT_W'(MAX_RUN - 1);
    localparam logic [CNT_W-1:0] MinOn    = CNT_W'(MIN_ON);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             sat_q, sat_d;

    // One extra bit so temp+HYST and setpoint+HYST cannot wrap.
    logic [TEMP_W:0] temp_x, sp_x, hyst_x;
    logic            heat_cond, cool_cond, heat_sat, cool_sat;

    assign temp_x    = {1'b0, temp};
    assign sp_x      = {1'b0, setpoint};
    assign hyst_x    = CW'(HYST);
    assign heat_cond = (temp_x + hyst_x) < sp_x;
    assign cool_cond = temp_x > (sp_x + hyst_x);
    assign heat_sat  = temp >= setpoint;
    assign cool_sat  = temp <= setpoint;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        run_cnt_d = run_cnt_q;
        sat_d     = sat_q;
        unique case (state_q)
            StDead: begin
                if (cnt_q == DeadLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StIdle: begin
                if (temp_valid && enable) begin
                    if (heat_cond) begin
                        state_d   = StHeat;
                        run_cnt_d = '0;
                        sat_d     = 1'b0;
                    end else if (cool_cond) begin
                        state_d   = StCool;
                        run_cnt_d = '0;
                        sat_d     = 1'b0;
                    end
                end
            end
            StHeat, StCool: begin
                run_cnt_d = run_cnt_q + CNT_W'(1);
                if (temp_valid) begin
                    sat_d = (state_q == StHeat) ? heat_sat : cool_sat;
                end
                // Disable beats the fault limit, which beats a satisfied exit.
                if (!enable) begin
                    state_d = StDead;
                    cnt_d   = '0;
                end else if (run_cnt_q == RunLast) begin
                    state_d = StFault;
                end else if (sat_q && (run_cnt_q >= MinOn)) begin
                    state_d = StDead;
                    cnt_d   = '0;
                end
            end
            StFault: begin
                if (clear_fault) begin
                    state_d = StDead;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StDead;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q   <= StDead;
            cnt_q     <= '0;
            run_cnt_q <= '0;
            sat_q     <= 1'b0;
            heat_req  <= 1'b0;
            cool_req  <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_cnt_q <= run_cnt_d;
            sat_q     <= sat_d;
            heat_req  <= (state_d == StHeat);
            cool_req  <= (state_d == StCool);
            fault     <= (state_d == StFault);
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_heating_sched.sv
// Directed bench for heating_sched: two instances (HYST=2 and HYST=0) share one stimulus stream.
module tb_heating_sched;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HEAT  = 3'd1;
    localparam logic [2:0] S_COOL  = 3'd2;
    localparam logic [2:0] S_DEAD  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic       clock, rst, enable, temp_valid, clear_fault;
    logic [7:0] temp, setpoint;
    logic       heat_req, cool_req, fault;
    logic [2:0] state_o;
    logic       heat0, cool0, fault0;
    logic [2:0] state0;

    int errors = 0;
    int checks = 0;

    heating_sched #(
        .TEMP_W(8), .HYST(2), .MIN_ON(4), .DEAD_CYC(3), .MAX_RUN(20), .CNT_W(12)
    ) u_dut (
        .clock(clock), .rst(rst), .enable(enable), .temp_valid(temp_valid), .temp(temp),
        .setpoint(setpoint), .clear_fault(clear_fault), .heat_req(heat_req),
        .cool_req(cool_req), .fault(fault), .state_o(state_o)
    );

    heating_sched #(
        .TEMP_W(8), .HYST(0), .MIN_ON(4), .DEAD_CYC(3), .MAX_RUN(20), .CNT_W(12)
    ) u_dut0 (
        .clock(clock), .rst(rst), .enable(enable), .temp_valid(temp_valid), .temp(temp),
        .setpoint(setpoint), .clear_fault(clear_fault), .heat_req(heat0),
        .cool_req(cool0), .fault(fault0), .state_o(state0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] exp);
        check(tag, {29'd0, state_o}, {29'd0, exp});
    endtask

    initial begin
        int cnt_h;
        int gap;
        int overlap;
        int seen_dead;
        int seen_cool;

        rst = 1'b0; enable = 1'b1; temp_valid = 1'b0; clear_fault = 1'b0;
        temp = 8'd0; setpoint = 8'd0;
        tick(); tick();
        check_state("reset_state", S_DEAD);
        check("reset_heat", {31'd0, heat_req}, 0);
        check("reset_cool", {31'd0, cool_req}, 0);
        check("reset_fault", {31'd0, fault}, 0);

        // Power-up lockout with a heat demand present throughout.
        temp = 8'd10; setpoint = 8'd20; temp_valid = 1'b1; rst = 1'b1;
        tick(); check_state("pwr_dead1", S_DEAD);
        tick(); check_state("pwr_dead2", S_DEAD);
        tick(); check_state("pwr_idle", S_IDLE);
        check("pwr_idle_heat", {31'd0, heat_req}, 0);
        tick(); check_state("pwr_heat", S_HEAT);
        check("pwr_heat_req", {31'd0, heat_req}, 1);

        // Max-run fault: heat stays demanded.
        cnt_h = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (heat_req) cnt_h++;
            else break;
        end
        check("maxrun_len", cnt_h, 20);
        check("maxrun_fault", {31'd0, fault}, 1);
        check_state("maxrun_state", S_FAULT);
        check("maxrun_cool", {31'd0, cool_req}, 0);
        enable = 1'b0;
        tick(); check_state("fault_ignores_enable", S_FAULT);
        enable = 1'b1; temp_valid = 1'b0; clear_fault = 1'b1;
        tick(); check_state("clear_dead0", S_DEAD);
        check("clear_fault_low", {31'd0, fault}, 0);
        clear_fault = 1'b0;
        tick(); check_state("clear_dead1", S_DEAD);
        tick(); check_state("clear_dead2", S_DEAD);
        tick(); check_state("clear_idle", S_IDLE);

        // Hysteresis boundaries, setpoint 20, HYST 2.
        temp_valid = 1'b1;
        temp = 8'd18; tick(); check_state("hyst_18_idle", S_IDLE);
        temp = 8'd22; tick(); check_state("hyst_22_idle", S_IDLE);
        temp = 8'd17; tick(); check_state("hyst_17_heat", S_HEAT);

        // Early satisfaction held off until run_cnt reaches MIN_ON.
        temp = 8'd25;
        tick(); check("early_heat_rc1", {31'd0, heat_req}, 1);
        temp_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            tick(); check("early_heat_hold", {31'd0, heat_req}, 1);
        end
        tick(); check_state("early_dead", S_DEAD);
        check("early_heat_off", {31'd0, heat_req}, 0);
        tick(); check_state("early_dead1", S_DEAD);
        tick(); check_state("early_dead2", S_DEAD);
        tick(); check_state("early_idle", S_IDLE);

        clear_fault = 1'b1;
        tick(); check_state("clear_in_idle", S_IDLE);
        clear_fault = 1'b0;

        // Cool entry, then disable on its second cycle.
        temp = 8'd23; temp_valid = 1'b1;
        tick(); check_state("hyst_23_cool", S_COOL);
        check("cool_req_on", {31'd0, cool_req}, 1);
        temp_valid = 1'b0;
        tick(); check("cool_2nd_cycle", {31'd0, cool_req}, 1);
        enable = 1'b0;
        tick(); check("disable_cool_off", {31'd0, cool_req}, 0);
        check_state("disable_dead", S_DEAD);
        enable = 1'b1;
        tick(); tick(); tick(); check_state("disable_idle", S_IDLE);

        // Mid-run reset.
        temp = 8'd10; temp_valid = 1'b1;
        tick(); check_state("rst_run_heat", S_HEAT);
        temp_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick(); check_state("rst_mid_dead", S_DEAD);
        check("rst_mid_heat", {31'd0, heat_req}, 0);
        rst = 1'b1;
        tick(); tick(); tick(); check_state("rst_mid_idle", S_IDLE);

        // HYST=0 instance: equality is neither condition, one below is heat.
        temp = 8'd20; setpoint = 8'd20; temp_valid = 1'b1;
        tick(); check("h0_eq_idle", {29'd0, state0}, {29'd0, S_IDLE});
        check_state("h2_eq_idle", S_IDLE);
        temp = 8'd19;
        tick(); check("h0_19_heat", {29'd0, state0}, {29'd0, S_HEAT});
        check("h0_19_heat_req", {31'd0, heat0}, 1);
        check("h0_19_cool_req", {31'd0, cool0}, 0);
        check("h0_19_fault", {31'd0, fault0}, 0);
        check_state("h2_19_idle", S_IDLE);

        // Mode reversal: heat run, then a hot reading drives a cool run.
        temp = 8'd17;
        tick(); check_state("rev_heat", S_HEAT);
        temp = 8'd30;
        gap = 0; overlap = 0; seen_dead = 0; seen_cool = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (heat_req && cool_req) overlap++;
            if (state_o == S_DEAD) seen_dead = 1;
            if (cool_req) begin
                seen_cool = 1;
                break;
            end
            if (!heat_req) gap++;
        end
        check("rev_cool_seen", seen_cool, 1);
        check("rev_overlap", overlap, 0);
        check("rev_via_dead", seen_dead, 1);
        check("rev_gap", gap, 4);
        check_state("rev_cool_state", S_COOL);
        enable = 1'b0;
        tick(); check_state("final_dead", S_DEAD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
